dff_pipeline_reg: RTL and testbench

- Parametrised successor to the team's single-bit D flip-flop: a WIDTH-bit, DEPTH-stage register pipeline with per-stage valid tracking.
- Adds global stall (en), synchronous clear, a programmable reset value and an occupancy counter.
- Used as a generic delay/retiming line between datapath blocks, so one verified primitive replaces hand-chained flops.

---
 rtl/dff_pkg.sv | 14 +
 rtl/dff_stage_en.sv | 31 +++
 rtl/dff_pipeline_reg.sv | 81 ++++++++
 tb/tb_dff_pipeline_reg.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/dff_pkg.sv
// Shared constants and helpers for the dff_pipeline_reg register line.
package dff_pkg;

  localparam int unsigned DefWidth = 8;
  localparam int unsigned DefDepth = 3;

  // Bits needed to hold an occupancy count in the range 0..depth.
  function automatic int unsigned cnt_width(input int unsigned depth);
    return (depth < 1) ? 1 : $clog2(depth + 1);
  endfunction

  localparam int unsigned DefCntWidth = cnt_width(DefDepth);

endpackage

// File: rtl/dff_stage_en.sv
// One pipeline stage: WIDTH-bit data register plus valid bit, with clear and advance enable.
module dff_stage_en
  import dff_pkg::*;
#(
  parameter int unsigned     WIDTH     = DefWidth,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  input  logic             d_valid,
  output logic [WIDTH-1:0] q,
  output logic             q_valid
);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      q       <= RESET_VAL;
      q_valid <= 1'b0;
    end else if (clr) begin
      q       <= RESET_VAL;
      q_valid <= 1'b0;
    end else if (en) begin
      q       <= d;
      q_valid <= d_valid;
    end
  end

endmodule

// File: rtl/dff_pipeline_reg.sv
// WIDTH-bit, DEPTH-stage register pipeline with per-stage valid tracking and occupancy count.
module dff_pipeline_reg
  import dff_pkg::*;
#(
  parameter int unsigned      WIDTH     = DefWidth,
  parameter int unsigned      DEPTH     = DefDepth,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         en,
  input  logic                         clr,
  input  logic [WIDTH-1:0]             d,
  input  logic                         d_valid,
  output logic [WIDTH-1:0]             q,
  output logic                         q_valid,
  output logic [cnt_width(DEPTH)-1:0]  count
);

  localparam int unsigned CntW = cnt_width(DEPTH);

  logic [WIDTH-1:0] data [DEPTH];
  logic [DEPTH-1:0] valid;
  logic [CntW-1:0]  count_q, count_d;

  for (genvar i = 0; i < DEPTH; i++) begin : g_stage
    logic [WIDTH-1:0] din;
    logic             vin;

    if (i == 0) begin : g_head
      assign din = d;
      assign vin = d_valid;
    end else begin : g_tail
      assign din = data[i-1];
      assign vin = valid[i-1];
    end

    dff_stage_en #(
      .WIDTH     (WIDTH),
      .RESET_VAL (RESET_VAL)
    ) u_stage (
      .clk     (clk),
      .reset   (reset),
      .clr     (clr),
      .en      (en),
      .d       (din),
      .d_valid (vin),
      .q       (data[i]),
      .q_valid (valid[i])
    );
  end

  // Entry and exit on the same shift cancel, so count cannot leave 0..DEPTH.
  always_comb begin
    count_d = count_q;
    if (en) begin
      count_d = count_q + CntW'(d_valid) - CntW'(valid[DEPTH-1]);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_q <= '0;
    end else if (clr) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign q       = data[DEPTH-1];
  assign q_valid = valid[DEPTH-1];
  assign count   = count_q;

  a_count_bound: assert property (@(posedge clk) disable iff (!reset)
    count_q <= CntW'(DEPTH));

  a_count_tracks_valid: assert property (@(posedge clk) disable iff (!reset)
    count_q == CntW'($countones(valid)));

endmodule

// File: tb/tb_dff_pipeline_reg.sv
// Directed bench for dff_pipeline_reg with a history-queue reference model.
module tb_dff_pipeline_reg;

  localparam int unsigned D  = 3;
  localparam logic [7:0]  RV = 8'hA5;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       en = 1'b0, clr = 1'b0, d_valid = 1'b0;
  logic [7:0] d = 8'h00;
  logic [7:0] q;
  logic       q_valid;
  logic [1:0] count;

  logic en1 = 1'b0, clr1 = 1'b0, d1 = 1'b0, dv1 = 1'b0;
  logic q1, qv1;
  logic [0:0] count1;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  dff_pipeline_reg #(
    .WIDTH     (8),
    .DEPTH     (D),
    .RESET_VAL (RV)
  ) u_dut (
    .clk     (clk),
    .reset   (reset),
    .en      (en),
    .clr     (clr),
    .d       (d),
    .d_valid (d_valid),
    .q       (q),
    .q_valid (q_valid),
    .count   (count)
  );

  dff_pipeline_reg #(
    .WIDTH     (1),
    .DEPTH     (1),
    .RESET_VAL (1'b1)
  ) u_dut1 (
    .clk     (clk),
    .reset   (reset),
    .en      (en1),
    .clr     (clr1),
    .d       (d1),
    .d_valid (dv1),
    .q       (q1),
    .q_valid (qv1),
    .count   (count1)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: history of entries accepted since the last reset/clear; the output is
  // the entry accepted DEPTH enabled edges ago, or the reset value if there is none.
  typedef struct packed {
    logic [7:0] data;
    logic       valid;
  } ent_t;

  ent_t mq[$];

  always @(negedge reset) mq.delete();

  always @(posedge clk) begin
    if (reset) begin
      if (clr) begin
        mq.delete();
      end else if (en) begin
        mq.push_back('{data: d, valid: d_valid});
        if (mq.size() > D) void'(mq.pop_front());
      end
    end
  end

  function automatic logic [7:0] m_q();
    return (mq.size() == D) ? mq[0].data : RV;
  endfunction

  function automatic logic m_v();
    return (mq.size() == D) ? mq[0].valid : 1'b0;
  endfunction

  function automatic int m_cnt();
    int n = 0;
    foreach (mq[i]) n += int'(mq[i].valid);
    return n;
  endfunction

  // Single-stage model: output is whatever was sampled at the last enabled edge.
  logic last_d, last_dv;
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      last_d  <= 1'b1;
      last_dv <= 1'b0;
    end else if (en1) begin
      last_d  <= d1;
      last_dv <= dv1;
    end
  end

  always @(negedge clk) begin
    check("model_q", q, m_q());
    check("model_q_valid", q_valid, m_v());
    check("model_count", count, m_cnt());
    check("d1_q", q1, last_d);
    check("d1_q_valid", qv1, last_dv);
    check("d1_count", count1, last_dv);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  int peak;

  initial begin
    // Reset held with live inputs.
    #1 reset = 1'b0;
    en = 1'b1; d = 8'h3C; d_valid = 1'b1;
    repeat (2) begin
      tick();
      check("rst_q", q, RV);
      check("rst_qv", q_valid, 1'b0);
      check("rst_cnt", count, 0);
    end

    // Streaming.
    d = 8'h01;
    reset = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("stream_cnt", count, (i < 2) ? i + 1 : 3);
      if (i >= 2) begin
        check("stream_q", q, i - 1);
        check("stream_qv", q_valid, 1'b1);
      end
      d = 8'(i + 2);
    end

    // Reset between edges acts immediately.
    @(posedge clk);
    #3 reset = 1'b0;
    #1;
    check("async_rst_q", q, RV);
    check("async_rst_qv", q_valid, 1'b0);
    check("async_rst_cnt", count, 0);
    tick();
    reset = 1'b1;

    // Stall.
    en = 1'b1; d = 8'h11; d_valid = 1'b1;
    tick();
    d = 8'h22;
    tick();
    check("pre_stall_cnt", count, 2);
    en = 1'b0; d = 8'hFF;
    repeat (4) begin
      tick();
      check("stall_q", q, RV);
      check("stall_qv", q_valid, 1'b0);
      check("stall_cnt", count, 2);
    end
    en = 1'b1; d = 8'h00; d_valid = 1'b0;
    tick();
    check("resume_q", q, 8'h11);
    check("resume_qv", q_valid, 1'b1);
    check("resume_cnt", count, 2);
    tick();
    check("resume_q2", q, 8'h22);
    check("resume_cnt2", count, 1);
    tick();
    check("resume_cnt3", count, 0);

    // Bubbles, including an unknown d with d_valid low.
    peak = 0;
    d = 8'h10; d_valid = 1'b1;
    tick(); if (int'(count) > peak) peak = int'(count);
    d = 8'h20; d_valid = 1'b0;
    tick(); if (int'(count) > peak) peak = int'(count);
    d = 8'h30; d_valid = 1'b1;
    tick(); if (int'(count) > peak) peak = int'(count);
    check("bub_q0", q, 8'h10);
    check("bub_qv0", q_valid, 1'b1);
    d = 'x; d_valid = 1'b0;
    tick(); if (int'(count) > peak) peak = int'(count);
    check("bub_qv1", q_valid, 1'b0);
    check("bub_cnt1", count, 1);
    tick(); if (int'(count) > peak) peak = int'(count);
    check("bub_q2", q, 8'h30);
    check("bub_qv2", q_valid, 1'b1);
    tick();
    check("x_qv", q_valid, 1'b0);
    check("x_cnt", count, 0);
    check("bub_peak", peak, 2);

    // Clear beats enable.
    d_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      d = 8'(8'h41 + i);
      tick();
    end
    check("full_cnt", count, 3);
    clr = 1'b1; d = 8'h77;
    tick();
    check("clr_q", q, RV);
    check("clr_qv", q_valid, 1'b0);
    check("clr_cnt", count, 0);
    clr = 1'b0; d = 8'h00; d_valid = 1'b0;
    repeat (3) begin
      tick();
      check("no_77", q == 8'h77, 1'b0);
    end
    en = 1'b0;

    // Single-bit, single-stage instance.
    en1 = 1'b1; d1 = 1'b0; dv1 = 1'b1;
    tick();
    check("d1_lit_q", q1, 1'b0);
    check("d1_lit_cnt", count1, 1'b1);
    en1 = 1'b0; d1 = 1'b1; dv1 = 1'b0;
    tick();
    check("d1_hold_q", q1, 1'b0);
    check("d1_hold_cnt", count1, 1'b1);
    for (int i = 0; i < 15; i++) begin
      en1 = 1'($urandom_range(0, 1));
      d1  = 1'($urandom_range(0, 1));
      dv1 = 1'($urandom_range(0, 1));
      tick();
    end
    en1 = 1'b0;
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
